// File: rtl/lane_mux_pkg.sv
// -----------------------------------------------------------------------------
// lane_mux_pkg
// Shared definitions for the lane-tagged mux/demux family:
//   - default parameter values for LANES / WIDTH / DEPTH
//   - tagWidth(): width of the lane tag carried next to each data word
//   - rrFirst():  round-robin search, returns the first requesting lane at or
//                 above a pointer (wrapping), or -1 when nobody requests.
// -----------------------------------------------------------------------------
package lane_mux_pkg;

  localparam int LANES_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // Upper bound on lanes; rrFirst works on a request vector of this width.
  localparam int MAX_LANES = 16;

  // A single lane still needs a 1-bit tag so the port never collapses to zero width.
  function automatic int tagWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Offsets are scanned from the far end down so that the smallest offset
  // from ptr is the last one written, i.e. the winner.
  function automatic int rrFirst(input logic [MAX_LANES-1:0] req,
                                 input int                   lanes,
                                 input int                   ptr);
    int idx;
    int res;
    res = -1;
    for (int k = MAX_LANES - 1; k >= 0; k--) begin
      if (k < lanes) begin
        idx = ptr + k;
        if (idx >= lanes) idx = idx - lanes;
        if (req[idx[3:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// -----------------------------------------------------------------------------
// lane_fifo
// Per-lane buffer of DEPTH words with an explicit occupancy count, so full and
// empty never alias. A push while full is accepted only when the same cycle
// pops, which keeps the count unchanged.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-low; clears pointers and count
//   push      write request (ignored when full and not popping)
//   pushData  word to write
//   pop       read request (ignored when empty)
//   popData   head word, valid whenever !empty
//   count     number of stored words, 0..DEPTH
//   full      count == DEPTH
//   empty     count == 0
// -----------------------------------------------------------------------------
module lane_fifo
  import lane_mux_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/lane_rr_mux.sv
// -----------------------------------------------------------------------------
// lane_rr_mux
// Merges LANES byte lanes into one tagged output stream. Each lane has its own
// FIFO; a work-conserving round-robin arbiter picks the next non-empty lane at
// or above the rr pointer whenever the output register may advance.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-low
//   dataIn    LANES*WIDTH, lane i at [i*WIDTH +: WIDTH]
//   validIn   per-lane write strobe
//   fullOut   per-lane FIFO full (advisory)
//   overflow  per-lane sticky drop flag, cleared only by reset
//   dataOut   output word
//   laneOut   source lane of dataOut
//   validOut  dataOut/laneOut valid
//   readyIn   downstream accepts the word this cycle
// -----------------------------------------------------------------------------
module lane_rr_mux
  import lane_mux_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LANE_W = tagWidth(LANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] dataIn,
  input  logic [LANES-1:0]       validIn,
  output logic [LANES-1:0]       fullOut,
  output logic [LANES-1:0]       overflow,
  output logic [WIDTH-1:0]       dataOut,
  output logic [LANE_W-1:0]      laneOut,
  output logic                   validOut,
  input  logic                   readyIn
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [LANES-1:0]  pop;
  logic [LANES-1:0]  full;
  logic [LANES-1:0]  empty;
  logic [LANES-1:0]  drop;
  logic [WIDTH-1:0]  popData [LANES];
  logic [CNT_W-1:0]  count   [LANES];
  logic [LANE_W-1:0] rrPtr;
  logic [LANE_W-1:0] sel;
  logic              anyReq;
  logic              adv;
  int                gnt;

  // Stage p0: per-lane FIFOs
  for (genvar i = 0; i < LANES; i++) begin : gLane
    lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) uFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (validIn[i]),
      .pushData (dataIn[i*WIDTH +: WIDTH]),
      .pop      (pop[i]),
      .popData  (popData[i]),
      .count    (count[i]),
      .full     (full[i]),
      .empty    (empty[i])
    );

    // A full lane only loses the word when it is not being drained this cycle.
    assign drop[i]    = validIn[i] && full[i] && !pop[i];
    assign fullOut[i] = (count[i] == CNT_W'(DEPTH));
  end

  assign adv = !validOut || readyIn;

  always_comb begin
    pop    = '0;
    gnt    = rrFirst(MAX_LANES'(~empty), LANES, int'(rrPtr));
    anyReq = (gnt >= 0);
    sel    = anyReq ? LANE_W'(gnt) : '0;
    if (adv && anyReq) pop[sel] = 1'b1;
  end

  // Stage p1: output register and arbitration state
  always_ff @(posedge clk) begin
    if (!reset) begin
      rrPtr    <= '0;
      validOut <= 1'b0;
      dataOut  <= '0;
      laneOut  <= '0;
      overflow <= '0;
    end else begin
      overflow <= overflow | drop;
      if (adv) begin
        if (anyReq) begin
          validOut <= 1'b1;
          dataOut  <= popData[sel];
          laneOut  <= sel;
          rrPtr    <= (sel == LANE_W'(LANES - 1)) ? '0 : sel + 1'b1;
        end else begin
          validOut <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/lane_rr_mux.md
Name: lane_rr_mux

Overview:
- Parametrised successor to the two-level 4→2→1 lane muxes.
- Merges LANES independent byte lanes onto one output stream in a single clock domain.
- Each lane is buffered in its own DEPTH-entry FIFO.
- A work-conserving round-robin arbiter skips idle lanes, and every output word carries its lane tag so the downstream demux can route it without a shared selector.
- Adds downstream backpressure, per-lane full flags and sticky overflow flags.

Parameters:
LANES, 4, number of input lanes (2..16)
WIDTH, 8, data bits per lane
DEPTH, 4, entries per lane FIFO (power of two, ≥2)
LANE_W, $clog2(LANES), width of the lane tag

Ports:
clk  in  1  sole clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (sampled on clk rising edge)
dataIn  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
validIn  in  LANES  lane i presents a word this cycle
fullOut  out  LANES  lane i FIFO holds DEPTH entries (registered count)
overflow  out  LANES  sticky: lane i dropped a word since reset
dataOut  out  WIDTH  output word
laneOut  out  LANE_W  source lane of dataOut
validOut  out  1  dataOut/laneOut valid
readyIn  in  1  downstream accepts the word this cycle

Behaviour:
- Reset (reset==0 at a clk edge):
  - All FIFOs empty, read/write pointers 0, counts 0.
  - rr pointer = 0 (lane 0 checked first).
  - validOut=0, dataOut=0, laneOut=0, fullOut=0, overflow=0.
  - Reset mid-operation discards all buffered and output-held words; nothing is emitted afterwards.
- Push, per lane: validIn[i] writes dataIn lane i when count<DEPTH, or when count==DEPTH and the same lane is popped in that cycle. In the second case the count is unchanged.
- Drop: validIn[i] with count==DEPTH and no pop on lane i. The word is discarded, overflow[i] is set and held until reset. Other lanes are unaffected.
- Output register advance condition: adv = !validOut || readyIn.
  - When adv: the arbiter selects the first non-empty lane starting at the rr pointer and going upward modulo LANES. It pops that lane, loads dataOut/laneOut, sets validOut=1, and sets rr = selected+1 (wrapping LANES-1 → 0).
  - When adv and all FIFOs are empty: validOut=0; dataOut/laneOut hold their last values; rr unchanged.
  - When validOut && !readyIn: dataOut, laneOut and validOut hold stable; no pop.
- Arbitration considers FIFO contents only. A word pushed in cycle t is eligible at edge t+1.
  - Minimum latency validIn→validOut is 2 edges.
  - Sustained throughput is 1 word/cycle with readyIn=1.
- Fairness: with all lanes continuously non-empty, grant order is 0,1,…,LANES-1,0,…; each lane is served at least once every LANES output words.
- FIFO pointers wrap modulo DEPTH. The count is held separately, so full and empty are unambiguous.
- fullOut[i] = (count_i==DEPTH), registered. It is advisory only; the upstream source may ignore it and accept drops.
- No X propagation: unused dataIn bits when validIn=0 never reach dataOut.

Decomposition:
- Shared package lane_mux_pkg holds:
  - default parameter values (LANES_DEF=4, WIDTH_DEF=8, DEPTH_DEF=4);
  - the lane-tag width function;
  - a round-robin "first set bit at or above pointer" function, reused by the companion tag-routed demux.
- One sub-module, lane_fifo (WIDTH, DEPTH), instantiated LANES times via generate.
  - Ports: clk, reset, push, pushData, pop, popData, count, full, empty.
  - Handles simultaneous push/pop when full.
- Arbiter and output register live in lane_rr_mux.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles with validIn=4'hF → after release, validOut=0, fullOut=0, overflow=0, dataOut=0; first word appears only after new pushes.
- Single lane: lane 2 pushes 8'hA5 at cycle t, readyIn=1 → validOut=1, dataOut=8'hA5, laneOut=2 at edge t+2; validOut=0 the following cycle.
- Round-robin: all 4 lanes push one word each in the same cycle (8'h10,8'h21,8'h32,8'h43), readyIn=1 → output lanes 0,1,2,3 on consecutive cycles with matching data; rr then points at 0.
- Skip idle: lanes 1 and 3 each push 2 words, readyIn=1 → lane order 1,3,1,3 with no bubbles.
- Backpressure and overflow: readyIn=0, lane 0 pushes 6 words (8'h01..8'h06), DEPTH=4 → validOut=1 holding 8'h01. FIFO then holds 02..05 with fullOut[0]=1; 8'h06 is dropped and overflow[0]=1. After readyIn=1 the output is 01,02,03,04,05, and overflow stays 1.
- Full with simultaneous push/pop: lane 1 full, readyIn=1, validIn[1]=1 every cycle → no drops, overflow[1]=0, fullOut[1] stays 1, output stream is in-order with no gaps. Then assert reset=0 mid-stream → validOut=0 next edge and all counts are 0.
